// File: rtl/regfile_pkg.sv
// Shared widths, register-index type and mask helper for the register-file writeback block.
// Pure definitions: no latency, no flow control.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [NREG-1:0]   reg_vec_t;

    localparam reg_idx_t ZERO_REG = reg_idx_t'(31);

    // One-hot mask of a register; the hard-wired zero register never gets a bit.
    function automatic reg_vec_t reg_mask(input reg_idx_t idx);
        reg_vec_t m;
        m = '0;
        if (idx != ZERO_REG) begin
            m[idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from req and last_grant.
// Grant is forced low during reset so no transfer is accepted then.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic       r_last_grant;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (!reset) begin
            // Requester 0 wins unless requester 1 is also waiting and 0 was served last.
            if (req[0] && (!req[1] || r_last_grant)) begin
                w_gnt[0] = 1'b1;
            end else if (req[1]) begin
                w_gnt[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_gnt[0]) begin
            r_last_grant <= 1'b0;
        end else if (w_gnt[1]) begin
            r_last_grant <= 1'b1;
        end
    end

    assign gnt = w_gnt;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Arbitrates two writeback requesters onto one regfile write port (1-cycle output register),
// tracks pending writes per register and raises read hazards / decode stall; no backpressure from regfile.
module regfile_wb_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic              wb_valid0,
    input  logic [ADDR_W-1:0] wb_reg0,
    input  logic [DATA_W-1:0] wb_data0,
    output logic              wb_ready0,

    input  logic              wb_valid1,
    input  logic [ADDR_W-1:0] wb_reg1,
    input  logic [DATA_W-1:0] wb_data1,
    output logic              wb_ready1,

    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,

    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_reg,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic              use1,
    input  logic              use2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              stall,
    output logic [NREG-1:0]   busy
);

    logic [1:0]        w_gnt;
    logic              w_fire;
    reg_idx_t          w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_reg_write;
    reg_idx_t          r_write_reg;
    logic [DATA_W-1:0] r_write_data;

    reg_vec_t          r_busy;
    reg_vec_t          w_busy_set;
    reg_vec_t          w_busy_clr;
    reg_vec_t          w_busy_nxt;

    logic              w_haz1;
    logic              w_haz2;
    logic              w_waw;
    logic              w_stall;
    logic              w_rsv_accept;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({wb_valid1, wb_valid0}),
        .gnt   (w_gnt)
    );

    assign w_fire     = w_gnt[0] | w_gnt[1];
    assign w_sel_reg  = w_gnt[1] ? wb_reg1  : wb_reg0;
    assign w_sel_data = w_gnt[1] ? wb_data1 : wb_data0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (w_fire) begin
            // Zero-register writes are accepted upstream but never reach the regfile.
            r_reg_write  <= (w_sel_reg != ZERO_REG);
            r_write_reg  <= w_sel_reg;
            r_write_data <= w_sel_data;
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

    // A source is stale if a write is pending upstream or sits in the output register.
    always_comb begin
        w_haz1 = 1'b0;
        w_haz2 = 1'b0;
        w_waw  = 1'b0;
        if (!reset) begin
            w_haz1 = use1 && (ReadRegister1 != ZERO_REG) &&
                     (r_busy[ReadRegister1] || (r_reg_write && (r_write_reg == ReadRegister1)));
            w_haz2 = use2 && (ReadRegister2 != ZERO_REG) &&
                     (r_busy[ReadRegister2] || (r_reg_write && (r_write_reg == ReadRegister2)));
            w_waw  = rsv_en && (rsv_reg != ZERO_REG) && r_busy[rsv_reg];
        end
    end

    assign w_stall      = w_haz1 | w_haz2 | w_waw;
    assign w_rsv_accept = rsv_en && (rsv_reg != ZERO_REG) && !w_stall;

    // Set is applied after clear so a same-edge reservation of the written register survives.
    always_comb begin
        w_busy_set = w_rsv_accept ? reg_mask(rsv_reg)   : '0;
        w_busy_clr = w_fire       ? reg_mask(w_sel_reg) : '0;
        w_busy_nxt = (r_busy & ~w_busy_clr) | w_busy_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign wb_ready0     = w_gnt[0];
    assign wb_ready1     = w_gnt[1];
    assign RegWrite      = r_reg_write;
    assign WriteRegister = r_write_reg;
    assign WriteData     = r_write_data;
    assign hazard1       = w_haz1;
    assign hazard2       = w_haz2;
    assign stall         = w_stall;
    assign busy          = r_busy;

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Writeback controller in front of the 32x64 register file `regfile`, which has one write port; X31 always reads as zero.
- Shares the single write port between two writeback requesters using round-robin arbitration with a valid/ready handshake:
  - requester 0 is the ALU/execute writeback;
  - requester 1 is the load/memory writeback.
- Holds a pending-write scoreboard, set by decode reservations and cleared at writeback.
- Produces read-hazard and issue-stall signals for the decode stage.

Parameters:
- DATA_W, 64, register data width.
- ADDR_W, 5, register index width.
- NREG, 32, number of architectural registers.
- ZERO_REG, 31, hard-wired zero register; never written, never busy.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wb_valid0  in  1  requester 0 has a write pending.
- wb_reg0  in  ADDR_W  requester 0 destination register.
- wb_data0  in  DATA_W  requester 0 write data.
- wb_ready0  out  1  requester 0 accepted this cycle.
- wb_valid1  in  1  requester 1 has a write pending.
- wb_reg1  in  ADDR_W  requester 1 destination register.
- wb_data1  in  DATA_W  requester 1 write data.
- wb_ready1  out  1  requester 1 accepted this cycle.
- RegWrite  out  1  to regfile write enable (registered).
- WriteRegister  out  ADDR_W  to regfile (registered).
- WriteData  out  DATA_W  to regfile (registered).
- rsv_en  in  1  decode reserves a destination register.
- rsv_reg  in  ADDR_W  destination register being reserved.
- ReadRegister1  in  ADDR_W  decode source 1, also driven to regfile.
- ReadRegister2  in  ADDR_W  decode source 2.
- use1  in  1  source 1 is live.
- use2  in  1  source 2 is live.
- hazard1  out  1  source 1 value in regfile is stale.
- hazard2  out  1  source 2 value in regfile is stale.
- stall  out  1  decode must hold this cycle.
- busy  out  NREG  scoreboard vector, for debug.

Behaviour:
- Reset values: RegWrite=0, WriteRegister=0, WriteData=0, busy=0, last_grant=1. While reset is high, wb_ready0/1=0, hazard1/2=0 and stall=0.
- Handshake: a transfer happens on a posedge where valid&ready. ready is combinational from the valids and last_grant. Requesters hold reg/data stable while valid is high and ready is low.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last wins.
  - On any grant, last_grant updates to the granted index next cycle.
  - No grant means last_grant is unchanged.
  - At most one ready high per cycle.
- Output stage, one register deep, no backpressure from regfile:
  - On a grant: WriteRegister/WriteData load the granted reg/data next cycle. RegWrite=1 unless the reg equals ZERO_REG.
  - No grant: RegWrite=0, WriteRegister/WriteData hold.
  - Latency: handshake at edge N → RegWrite high in cycle N..N+1 → data in regfile after edge N+1.
- ZERO_REG writes are accepted (ready=1) but dropped (RegWrite=0). busy is unaffected.
- Scoreboard (busy):
  - rsv_en with rsv_reg≠ZERO_REG sets busy[rsv_reg] at the next edge.
  - A grant clears busy[granted reg] at the handshake edge.
  - Set and clear of the same register on the same edge: set wins (newer reservation).
  - busy[ZERO_REG] is constant 0.
- Hazards, combinational:
  - hazardK = useK & (ReadRegisterK≠ZERO_REG) & (busy[ReadRegisterK] | (RegWrite & WriteRegister==ReadRegisterK)).
  - The second term covers a write sitting in the output stage that is not yet in the regfile.
  - No bypass data path is provided.
- stall = hazard1 | hazard2 | (rsv_en & rsv_reg≠ZERO_REG & busy[rsv_reg]). At most one outstanding write per register (WAW stall).
- A reservation presented while stall=1 is ignored; busy is not set. Decode re-presents it.
- A writeback to a non-busy register is legal: written normally, busy unchanged (stays 0).
- Reset mid-operation:
  - In-flight output-stage write is squashed (RegWrite=0 next cycle).
  - Pending handshakes are not accepted.
  - All busy bits are cleared.

Decomposition:
- Package regfile_pkg: DATA_W, ADDR_W, NREG, ZERO_REG constants and typedef reg_idx_t (logic [ADDR_W-1:0]).
- Sub-module rr_arb2: 2-way round-robin arbiter with last_grant state; inputs clk/reset/req[1:0], outputs gnt[1:0].
- Scoreboard and output stage stay in regfile_wb_ctrl.

Test Plan:
- ZERO_REG drop: wb_valid0=1, wb_reg0=31, wb_data0=64'hA0 → wb_ready0=1, RegWrite stays 0, busy=0; regfile X31 reads 0.
- Single requester write: wb_valid1=1, wb_reg1=5, wb_data1=64'h123456789ABCDEF0 → RegWrite=1, WriteRegister=5 the next cycle; regfile X5 reads 64'h123456789ABCDEF0 one cycle later.
- Round-robin: both valid for 4 cycles, regs 10/11, data 64'h1111…/64'h2222… → grants alternate 0,1,0,1; WriteRegister sequence 10,11,10,11.
- Scoreboard hazard: rsv_en, rsv_reg=7; next cycle ReadRegister1=7, use1=1 → hazard1=1, stall=1.
  - Then wb grant to reg 7 → busy[7] clears. hazard1 stays 1 one more cycle (output stage), then 0.
- Set-wins / WAW:
  - Same edge rsv_reg=3 and grant to reg 3 → busy[3]=1 after the edge.
  - A second rsv_reg=3 while busy → stall=1 and the reservation is ignored.
- Reset mid-op: assert reset in the cycle after a handshake to reg 9 with busy[9..12] set → RegWrite=0 next cycle, busy=0, and the next contention is granted to requester 0.
